// File: rtl/keccak_pkg.sv
// Shared types and constants for the Keccak absorb/pad front end.
// Mode encoding, absorb FSM states, per-mode rate and domain-suffix lookup.
package keccak_pkg;

  localparam int unsigned MAX_RATE_BYTES = 168;
  localparam logic [7:0]  SHA3_SUFFIX    = 8'h06;
  localparam logic [7:0]  SHAKE_SUFFIX   = 8'h1F;
  localparam logic [7:0]  PAD_END        = 8'h80;

  typedef enum logic [1:0] {
    ModeSha3_256 = 2'd0,
    ModeSha3_512 = 2'd1,
    ModeShake128 = 2'd2,
    ModeShake256 = 2'd3
  } keccak_mode_e;

  typedef enum logic {
    StAbsorb = 1'b0,
    StEmit   = 1'b1
  } absorb_state_e;

  function automatic logic [7:0] rate_bytes(input keccak_mode_e mode);
    logic [7:0] r;
    case (mode)
      ModeSha3_512: r = 8'd72;
      ModeShake128: r = 8'd168;
      default:      r = 8'd136;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] suffix_byte(input keccak_mode_e mode);
    return (mode inside {ModeShake128, ModeShake256}) ? SHAKE_SUFFIX : SHA3_SUFFIX;
  endfunction

endpackage

// File: rtl/keccak_byte_writer.sv
// Combinational byte-lane merge of count bytes of data into a block buffer at offset,
// clipped to the rate, with optional suffix/pad10*1 overlay at the new fill point.
module keccak_byte_writer #(
  parameter int unsigned DWIDTH            = 256,
  parameter int unsigned MAX_RATE_BYTES    = 168,
  parameter int unsigned VALID_BYTES_WIDTH = 6
) (
  input  logic [MAX_RATE_BYTES*8-1:0]  buf_i,
  input  logic [DWIDTH-1:0]            data_i,
  input  logic [VALID_BYTES_WIDTH-1:0] count_i,
  input  logic [7:0]                   offset_i,
  input  logic [7:0]                   rate_i,
  input  logic                         pad_i,
  input  logic [7:0]                   suffix_i,
  output logic [MAX_RATE_BYTES*8-1:0]  buf_o
);
  import keccak_pkg::*;

  int         rel;
  logic [4:0] lane;

  always_comb begin
    buf_o = buf_i;
    rel   = 0;
    lane  = '0;
    for (int i = 0; i < int'(MAX_RATE_BYTES); i++) begin
      rel  = i - int'(offset_i);
      lane = rel[4:0];
      if (rel >= 0 && rel < int'(count_i) && i < int'(rate_i)) begin
        buf_o[8*i +: 8] = data_i[{lane, 3'b000} +: 8];
      end
      // XOR overlay so suffix and end marker merge when they land on the same byte.
      if (pad_i && i == int'(offset_i) + int'(count_i)) begin
        buf_o[8*i +: 8] = buf_o[8*i +: 8] ^ suffix_i;
      end
      if (pad_i && i == int'(rate_i) - 1) begin
        buf_o[8*i +: 8] = buf_o[8*i +: 8] ^ PAD_END;
      end
    end
  end

endmodule

// File: rtl/keccak_absorb_pad.sv
// Packs message beats into rate-sized blocks, applies domain suffix and pad10*1,
// and hands blocks to the permutation over valid/ready.
module keccak_absorb_pad #(
  parameter int unsigned DWIDTH            = 256,
  parameter int unsigned MAX_RATE_BYTES    = 168,
  parameter int unsigned VALID_BYTES_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   mode_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [DWIDTH-1:0]            in_data_i,
  input  logic [VALID_BYTES_WIDTH-1:0] in_bytes_i,
  input  logic                         in_last_i,
  output logic                         blk_valid_o,
  input  logic                         blk_ready_i,
  output logic [MAX_RATE_BYTES*8-1:0]  blk_data_o,
  output logic [7:0]                   blk_rate_o,
  output logic                         blk_last_o
);
  import keccak_pkg::*;

  absorb_state_e                state_q;
  keccak_mode_e                 mode_q, mode_eff;
  logic [MAX_RATE_BYTES*8-1:0]  buf_q, wr_buf_in, wr_buf_out;
  logic [DWIDTH-1:0]            spill_q, wr_data;
  logic [VALID_BYTES_WIDTH-1:0] spill_cnt_q, wr_count;
  logic [7:0]                   fill_q, rate, room, suffix, wr_offset;
  logic [8:0]                   fill_sum;
  logic                         pend_last_q, pend_pad_q, final_q, msg_active_q, wr_pad;

  // The first beat of a message uses the incoming mode; later beats use the latched one.
  assign mode_eff = msg_active_q ? mode_q : keccak_mode_e'(mode_i);
  assign rate     = rate_bytes(mode_eff);
  assign suffix   = suffix_byte(mode_eff);
  assign room     = rate - fill_q;
  assign fill_sum = {1'b0, fill_q} + 9'(in_bytes_i);

  always_comb begin
    wr_buf_in = buf_q;
    wr_data   = in_data_i;
    wr_count  = in_bytes_i;
    wr_offset = fill_q;
    wr_pad    = 1'b0;
    if (state_q == StAbsorb) begin
      if (fill_sum > {1'b0, rate}) begin
        wr_count = VALID_BYTES_WIDTH'(room);
      end
      wr_pad = in_last_i && (fill_sum < {1'b0, rate});
    end else begin
      // Next block after a handshake starts from a cleared buffer plus any spill.
      wr_buf_in = '0;
      wr_data   = spill_q;
      wr_count  = spill_cnt_q;
      wr_offset = '0;
      wr_pad    = (spill_cnt_q != '0) ? pend_last_q : pend_pad_q;
    end
  end

  keccak_byte_writer #(
    .DWIDTH           (DWIDTH),
    .MAX_RATE_BYTES   (MAX_RATE_BYTES),
    .VALID_BYTES_WIDTH(VALID_BYTES_WIDTH)
  ) u_writer (
    .buf_i   (wr_buf_in),
    .data_i  (wr_data),
    .count_i (wr_count),
    .offset_i(wr_offset),
    .rate_i  (rate),
    .pad_i   (wr_pad),
    .suffix_i(suffix),
    .buf_o   (wr_buf_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StAbsorb;
      mode_q       <= ModeSha3_256;
      buf_q        <= '0;
      fill_q       <= '0;
      spill_q      <= '0;
      spill_cnt_q  <= '0;
      pend_last_q  <= 1'b0;
      pend_pad_q   <= 1'b0;
      final_q      <= 1'b0;
      msg_active_q <= 1'b0;
    end else begin
      case (state_q)
        StAbsorb: begin
          if (in_valid_i) begin
            mode_q       <= mode_eff;
            msg_active_q <= 1'b1;
            buf_q        <= wr_buf_out;
            if (fill_sum < {1'b0, rate}) begin
              fill_q <= fill_sum[7:0];
              if (in_last_i) begin
                state_q <= StEmit;
                final_q <= 1'b1;
              end
            end else if (fill_sum == {1'b0, rate}) begin
              fill_q     <= rate;
              state_q    <= StEmit;
              final_q    <= 1'b0;
              pend_pad_q <= in_last_i;
            end else begin
              fill_q      <= rate;
              spill_q     <= in_data_i >> {room, 3'b000};
              spill_cnt_q <= in_bytes_i - VALID_BYTES_WIDTH'(room);
              pend_last_q <= in_last_i;
              state_q     <= StEmit;
              final_q     <= 1'b0;
            end
          end
        end
        StEmit: begin
          if (blk_ready_i) begin
            fill_q      <= '0;
            spill_cnt_q <= '0;
            pend_last_q <= 1'b0;
            pend_pad_q  <= 1'b0;
            final_q     <= 1'b0;
            if (final_q) begin
              buf_q        <= '0;
              msg_active_q <= 1'b0;
              state_q      <= StAbsorb;
            end else begin
              buf_q <= wr_buf_out;
              if (spill_cnt_q != '0) begin
                fill_q <= 8'(spill_cnt_q);
                if (pend_last_q) begin
                  final_q <= 1'b1;
                end else begin
                  state_q <= StAbsorb;
                end
              end else if (pend_pad_q) begin
                final_q <= 1'b1;
              end else begin
                state_q <= StAbsorb;
              end
            end
          end
        end
        default: state_q <= StAbsorb;
      endcase
    end
  end

  assign in_ready_o  = (state_q == StAbsorb);
  assign blk_valid_o = (state_q == StEmit);
  assign blk_data_o  = buf_q;
  assign blk_last_o  = final_q;
  assign blk_rate_o  = rate_bytes(mode_q);

  a_beat_bytes : assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid_i && in_ready_o) |-> (in_bytes_i <= VALID_BYTES_WIDTH'(DWIDTH / 8)));

endmodule
